// File: rtl/ram_dp_arbiter_if.sv
// Bundle between the requester/RAM side and the dual-port RAM arbiter.
// The arbiter connects through the slave modport, the environment through master.
interface ram_dp_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int WIDTHAD = 10
);
  // Handshake: requester i transfers in a cycle where req_valid[i] and
  // req_ready[i] are both high. Ready is never raised without valid, and a
  // requester keeps valid, write, addr and wdata stable until that cycle.
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ-1:0]         req_write;
  logic [NUM_REQ*WIDTHAD-1:0] req_addr;
  logic [NUM_REQ*WIDTH-1:0]   req_wdata;
  logic [NUM_REQ-1:0]         rsp_valid;
  logic [NUM_REQ*WIDTH-1:0]   rsp_data;

  logic                       clken;
  logic [WIDTHAD-1:0]         address_a;
  logic [WIDTHAD-1:0]         address_b;
  logic                       read_en_a;
  logic                       read_en_b;
  logic                       write_en_a;
  logic                       write_en_b;
  logic [WIDTH-1:0]           write_data_a;
  logic [WIDTH-1:0]           write_data_b;
  logic [WIDTH-1:0]           read_data_a;
  logic [WIDTH-1:0]           read_data_b;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, read_data_a, read_data_b,
    output req_ready, rsp_valid, rsp_data, clken,
    output address_a, address_b, read_en_a, read_en_b,
    output write_en_a, write_en_b, write_data_a, write_data_b
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, read_data_a, read_data_b,
    input  req_ready, rsp_valid, rsp_data, clken,
    input  address_a, address_b, read_en_a, read_en_b,
    input  write_en_a, write_en_b, write_data_a, write_data_b
  );
endinterface

// File: rtl/ram_dp_arbiter.sv
// Round-robin arbiter granting up to two requesters per cycle onto the two
// ports of a dual-port RAM, with per-port read-response tracking.
module ram_dp_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int WIDTHAD = 10,
  parameter int LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  ram_dp_arbiter_if.slave              bus,
  output logic [$clog2(NUM_REQ)-1:0]   dbg_rr_ptr
);

  localparam int PW = $clog2(NUM_REQ);
  typedef logic [PW-1:0] idx_t;

  // Modular add on requester indices; base < NUM_REQ and off <= NUM_REQ.
  function automatic idx_t wrap_add(idx_t base, int unsigned off);
    logic [PW:0] sum;
    sum = {1'b0, base} + (PW+1)'(off);
    if (sum >= (PW+1)'(NUM_REQ)) sum = sum - (PW+1)'(NUM_REQ);
    return sum[PW-1:0];
  endfunction

  idx_t                         rr_ptr_q, rr_ptr_d;
  idx_t                         a_idx, b_idx;
  logic                         a_found, b_found;
  logic                         grant_a, grant_b, conflict;
  logic [WIDTHAD-1:0]           addr_a_c, addr_b_c;
  logic                         wr_a_c, wr_b_c;
  logic [WIDTH-1:0]             wd_a_c, wd_b_c;

  logic [LATENCY-1:0]           trk_a_vld_q, trk_a_vld_d;
  logic [LATENCY-1:0]           trk_b_vld_q, trk_b_vld_d;
  logic [LATENCY-1:0][PW-1:0]   trk_a_idx_q, trk_a_idx_d;
  logic [LATENCY-1:0][PW-1:0]   trk_b_idx_q, trk_b_idx_d;

  logic [NUM_REQ-1:0]           rsp_valid_c;
  logic [NUM_REQ*WIDTH-1:0]     rsp_data_q, rsp_data_d;

  // Port A takes the first valid requester from rr_ptr, port B the next one.
  always_comb begin
    a_found = 1'b0;
    b_found = 1'b0;
    a_idx   = '0;
    b_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (bus.req_valid[wrap_add(rr_ptr_q, k)]) begin
        if (!a_found) begin
          a_found = 1'b1;
          a_idx   = wrap_add(rr_ptr_q, k);
        end else if (!b_found) begin
          b_found = 1'b1;
          b_idx   = wrap_add(rr_ptr_q, k);
        end
      end
    end
  end

  // Same-address hazard with a write: B waits rather than taking a third requester.
  always_comb begin
    addr_a_c = bus.req_addr[a_idx*WIDTHAD +: WIDTHAD];
    addr_b_c = bus.req_addr[b_idx*WIDTHAD +: WIDTHAD];
    wr_a_c   = bus.req_write[a_idx];
    wr_b_c   = bus.req_write[b_idx];
    wd_a_c   = bus.req_wdata[a_idx*WIDTH +: WIDTH];
    wd_b_c   = bus.req_wdata[b_idx*WIDTH +: WIDTH];
    conflict = (addr_a_c == addr_b_c) && (wr_a_c || wr_b_c);
    grant_a  = a_found && !reset;
    grant_b  = b_found && !conflict && !reset;
  end

  always_comb begin
    bus.req_ready = '0;
    if (grant_a) bus.req_ready[a_idx] = 1'b1;
    if (grant_b) bus.req_ready[b_idx] = 1'b1;

    bus.clken        = 1'b1;
    bus.address_a    = grant_a ? addr_a_c : '0;
    bus.read_en_a    = grant_a && !wr_a_c;
    bus.write_en_a   = grant_a && wr_a_c;
    bus.write_data_a = grant_a ? wd_a_c : '0;
    bus.address_b    = grant_b ? addr_b_c : '0;
    bus.read_en_b    = grant_b && !wr_b_c;
    bus.write_en_b   = grant_b && wr_b_c;
    bus.write_data_b = grant_b ? wd_b_c : '0;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_a) rr_ptr_d = wrap_add(grant_b ? b_idx : a_idx, 1);
  end

  // Read tracking: stage 0 loads at the grant, the last stage lines up with RAM data.
  always_comb begin
    trk_a_vld_d    = trk_a_vld_q;
    trk_a_idx_d    = trk_a_idx_q;
    trk_b_vld_d    = trk_b_vld_q;
    trk_b_idx_d    = trk_b_idx_q;
    trk_a_vld_d[0] = grant_a && !wr_a_c;
    trk_a_idx_d[0] = a_idx;
    trk_b_vld_d[0] = grant_b && !wr_b_c;
    trk_b_idx_d[0] = b_idx;
    for (int s = 1; s < LATENCY; s++) begin
      trk_a_vld_d[s] = trk_a_vld_q[s-1];
      trk_a_idx_d[s] = trk_a_idx_q[s-1];
      trk_b_vld_d[s] = trk_b_vld_q[s-1];
      trk_b_idx_d[s] = trk_b_idx_q[s-1];
    end
  end

  // Response data bypasses straight from the RAM and is held afterwards.
  always_comb begin
    rsp_valid_c = '0;
    rsp_data_d  = rsp_data_q;
    if (trk_a_vld_q[LATENCY-1] && !reset) begin
      rsp_valid_c[trk_a_idx_q[LATENCY-1]] = 1'b1;
      rsp_data_d[trk_a_idx_q[LATENCY-1]*WIDTH +: WIDTH] = bus.read_data_a;
    end
    if (trk_b_vld_q[LATENCY-1] && !reset) begin
      rsp_valid_c[trk_b_idx_q[LATENCY-1]] = 1'b1;
      rsp_data_d[trk_b_idx_q[LATENCY-1]*WIDTH +: WIDTH] = bus.read_data_b;
    end
  end

  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_data  = rsp_data_d;
  assign dbg_rr_ptr    = rr_ptr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      trk_a_vld_q <= '0;
      trk_a_idx_q <= '0;
      trk_b_vld_q <= '0;
      trk_b_idx_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      trk_a_vld_q <= trk_a_vld_d;
      trk_a_idx_q <= trk_a_idx_d;
      trk_b_vld_q <= trk_b_vld_d;
      trk_b_idx_q <= trk_b_idx_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_ram_dp_arbiter.sv
// Directed bench for ram_dp_arbiter: a LATENCY=3 and a LATENCY=2 instance
// share one stimulus stream, each with its own dual-port RAM model.
module tb_ram_dp_arbiter;
  localparam int NR = 4;
  localparam int W  = 32;
  localparam int AW = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] ptr3, ptr2;
  int         n_tests = 0;
  int         n_fail  = 0;

  ram_dp_arbiter_if #(.NUM_REQ(NR), .WIDTH(W), .WIDTHAD(AW)) bus3 ();
  ram_dp_arbiter_if #(.NUM_REQ(NR), .WIDTH(W), .WIDTHAD(AW)) bus2 ();

  ram_dp_arbiter #(.NUM_REQ(NR), .WIDTH(W), .WIDTHAD(AW), .LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3.slave), .dbg_rr_ptr(ptr3)
  );
  ram_dp_arbiter #(.NUM_REQ(NR), .WIDTH(W), .WIDTHAD(AW), .LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave), .dbg_rr_ptr(ptr2)
  );

  always #5 clk = ~clk;

  assign bus2.req_valid = bus3.req_valid;
  assign bus2.req_write = bus3.req_write;
  assign bus2.req_addr  = bus3.req_addr;
  assign bus2.req_wdata = bus3.req_wdata;

  // RAM models: read data appears LATENCY cycles after the read-enable cycle.
  logic [W-1:0] mem3 [0:1023];
  logic [W-1:0] pa3 [0:2];
  logic [W-1:0] pb3 [0:2];
  always @(posedge clk) begin
    if (bus3.write_en_a) mem3[bus3.address_a] <= bus3.write_data_a;
    if (bus3.write_en_b) mem3[bus3.address_b] <= bus3.write_data_b;
    pa3[0] <= bus3.read_en_a ? mem3[bus3.address_a] : '0;
    pb3[0] <= bus3.read_en_b ? mem3[bus3.address_b] : '0;
    for (int s = 1; s < 3; s++) begin
      pa3[s] <= pa3[s-1];
      pb3[s] <= pb3[s-1];
    end
  end
  assign bus3.read_data_a = pa3[2];
  assign bus3.read_data_b = pb3[2];

  logic [W-1:0] mem2 [0:1023];
  logic [W-1:0] pa2 [0:1];
  logic [W-1:0] pb2 [0:1];
  always @(posedge clk) begin
    if (bus2.write_en_a) mem2[bus2.address_a] <= bus2.write_data_a;
    if (bus2.write_en_b) mem2[bus2.address_b] <= bus2.write_data_b;
    pa2[0] <= bus2.read_en_a ? mem2[bus2.address_a] : '0;
    pb2[0] <= bus2.read_en_b ? mem2[bus2.address_b] : '0;
    pa2[1] <= pa2[0];
    pb2[1] <= pb2[0];
  end
  assign bus2.read_data_a = pa2[1];
  assign bus2.read_data_b = pb2[1];

  task automatic clear_reqs();
    bus3.req_valid = '0;
    bus3.req_write = '0;
    bus3.req_addr  = '0;
    bus3.req_wdata = '0;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [W-1:0] d);
    bus3.req_valid[i]          = 1'b1;
    bus3.req_write[i]          = wr;
    bus3.req_addr[i*AW +: AW]  = a;
    bus3.req_wdata[i*W +: W]   = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    next_cycle();
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, AW'(i), '0);
    settle();
    n_tests++;
    if (bus3.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", bus3.req_ready); end
    n_tests++;
    if ({bus3.read_en_a, bus3.write_en_a, bus3.read_en_b, bus3.write_en_b} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_enables: got %b want 0000", {bus3.read_en_a, bus3.write_en_a, bus3.read_en_b, bus3.write_en_b});
    end
    n_tests++;
    if (bus3.clken !== 1'b1) begin n_fail++; $display("FAIL reset_clken: got %b want 1", bus3.clken); end
    next_cycle();
    reset = 1'b0;
    clear_reqs();
    settle();
    n_tests++;
    if (ptr3 !== 2'd0 || ptr2 !== 2'd0) begin n_fail++; $display("FAIL reset_rr_ptr: got %0d/%0d want 0/0", ptr3, ptr2); end
    n_tests++;
    if (bus3.rsp_valid !== 4'b0000 || bus3.rsp_data !== '0) begin
      n_fail++; $display("FAIL reset_rsp: got valid %b data %h want 0", bus3.rsp_valid, bus3.rsp_data);
    end
    n_tests++;
    if (bus3.address_a !== '0 || bus3.address_b !== '0) begin
      n_fail++; $display("FAIL idle_address: got %h/%h want 0/0", bus3.address_a, bus3.address_b);
    end
  endtask

  task automatic test_round_robin();
    next_cycle();
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, AW'(32 + i), '0);
    settle();
    n_tests++;
    if (bus3.req_ready !== 4'b0011 || bus3.address_a !== 10'h020 || bus3.address_b !== 10'h021) begin
      n_fail++; $display("FAIL rr_cycle0: got ready %b addr %h/%h want 0011 020/021", bus3.req_ready, bus3.address_a, bus3.address_b);
    end
    n_tests++;
    if ({bus3.read_en_a, bus3.write_en_a, bus3.read_en_b, bus3.write_en_b} !== 4'b1010) begin
      n_fail++; $display("FAIL rr_enables: got %b want 1010", {bus3.read_en_a, bus3.write_en_a, bus3.read_en_b, bus3.write_en_b});
    end
    next_cycle();
    settle();
    n_tests++;
    if (bus3.req_ready !== 4'b1100 || bus3.address_a !== 10'h022) begin
      n_fail++; $display("FAIL rr_cycle1: got ready %b addr_a %h want 1100 022", bus3.req_ready, bus3.address_a);
    end
    next_cycle();
    settle();
    n_tests++;
    if (bus3.req_ready !== 4'b0011) begin n_fail++; $display("FAIL rr_cycle2: got %b want 0011", bus3.req_ready); end
    next_cycle();
    clear_reqs();
    settle();
    n_tests++;
    if (ptr3 !== 2'd2) begin n_fail++; $display("FAIL rr_ptr_after: got %0d want 2", ptr3); end
    repeat (4) next_cycle();
  endtask

  task automatic test_read_latency();
    next_cycle();
    clear_reqs();
    set_req(2, 1'b1, 10'h010, 32'hDEADBEEF);
    settle();
    n_tests++;
    if (bus3.req_ready !== 4'b0100 || bus3.address_a !== 10'h010 || bus3.write_data_a !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL lat_write_grant: got ready %b addr %h data %h want 0100 010 deadbeef", bus3.req_ready, bus3.address_a, bus3.write_data_a);
    end
    n_tests++;
    if ({bus3.read_en_a, bus3.write_en_a, bus3.read_en_b, bus3.write_en_b} !== 4'b0100) begin
      n_fail++; $display("FAIL lat_write_enables: got %b want 0100", {bus3.read_en_a, bus3.write_en_a, bus3.read_en_b, bus3.write_en_b});
    end
    next_cycle();
    clear_reqs();
    set_req(2, 1'b0, 10'h010, '0);
    settle();
    n_tests++;
    if (bus3.req_ready !== 4'b0100 || {bus3.read_en_a, bus3.write_en_a, bus3.read_en_b, bus3.write_en_b} !== 4'b1000) begin
      n_fail++; $display("FAIL lat_read_grant: got ready %b want 0100 with read_en_a only", bus3.req_ready);
    end
    next_cycle();
    clear_reqs();
    settle();
    n_tests++;
    if (bus3.rsp_valid !== 4'b0000 || bus2.rsp_valid !== 4'b0000) begin
      n_fail++; $display("FAIL lat_plus1_quiet: got %b/%b want 0000/0000", bus3.rsp_valid, bus2.rsp_valid);
    end
    next_cycle();
    settle();
    n_tests++;
    if (bus3.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL lat_plus2_quiet: got %b want 0000", bus3.rsp_valid); end
    n_tests++;
    if (bus2.rsp_valid !== 4'b0100 || bus2.rsp_data[2*W +: W] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL lat2_response: got %b %h want 0100 deadbeef", bus2.rsp_valid, bus2.rsp_data[2*W +: W]);
    end
    next_cycle();
    settle();
    n_tests++;
    if (bus3.rsp_valid !== 4'b0100 || bus3.rsp_data[2*W +: W] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL lat3_response: got %b %h want 0100 deadbeef", bus3.rsp_valid, bus3.rsp_data[2*W +: W]);
    end
    next_cycle();
    settle();
    n_tests++;
    if (bus3.rsp_valid !== 4'b0000 || bus3.rsp_data[2*W +: W] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL lat3_hold: got %b %h want 0000 deadbeef", bus3.rsp_valid, bus3.rsp_data[2*W +: W]);
    end
  endtask

  task automatic test_write_read_conflict();
    next_cycle();
    clear_reqs();
    set_req(0, 1'b1, 10'h005, 32'hA5A50005);
    set_req(1, 1'b0, 10'h005, '0);
    settle();
    n_tests++;
    if (bus3.req_ready !== 4'b0001 || bus3.address_b !== '0) begin
      n_fail++; $display("FAIL conflict_grant: got ready %b addr_b %h want 0001 000", bus3.req_ready, bus3.address_b);
    end
    n_tests++;
    if ({bus3.read_en_a, bus3.write_en_a, bus3.read_en_b, bus3.write_en_b} !== 4'b0100) begin
      n_fail++; $display("FAIL conflict_enables: got %b want 0100", {bus3.read_en_a, bus3.write_en_a, bus3.read_en_b, bus3.write_en_b});
    end
    next_cycle();
    bus3.req_valid[0] = 1'b0;
    settle();
    n_tests++;
    if (bus3.req_ready !== 4'b0010 || bus3.address_a !== 10'h005 || bus3.read_en_a !== 1'b1) begin
      n_fail++; $display("FAIL conflict_retry: got ready %b addr %h rd %b want 0010 005 1", bus3.req_ready, bus3.address_a, bus3.read_en_a);
    end
    next_cycle();
    clear_reqs();
    repeat (2) next_cycle();
    settle();
    n_tests++;
    if (bus3.rsp_valid !== 4'b0010 || bus3.rsp_data[1*W +: W] !== 32'hA5A50005) begin
      n_fail++; $display("FAIL conflict_new_data: got %b %h want 0010 a5a50005", bus3.rsp_valid, bus3.rsp_data[1*W +: W]);
    end
  endtask

  task automatic test_dual_response();
    next_cycle();
    clear_reqs();
    set_req(1, 1'b1, 10'h030, 32'h11111111);
    set_req(3, 1'b1, 10'h040, 32'h33333333);
    settle();
    n_tests++;
    if (bus3.req_ready !== 4'b1010 || bus3.address_a !== 10'h040 || bus3.address_b !== 10'h030 || bus3.write_data_b !== 32'h11111111) begin
      n_fail++; $display("FAIL dual_write_grant: got ready %b addr %h/%h wdb %h want 1010 040/030 11111111",
                         bus3.req_ready, bus3.address_a, bus3.address_b, bus3.write_data_b);
    end
    next_cycle();
    clear_reqs();
    set_req(1, 1'b0, 10'h030, '0);
    set_req(3, 1'b0, 10'h040, '0);
    settle();
    n_tests++;
    if (bus3.req_ready !== 4'b1010 || {bus3.read_en_a, bus3.write_en_a, bus3.read_en_b, bus3.write_en_b} !== 4'b1010) begin
      n_fail++; $display("FAIL dual_read_grant: got ready %b want 1010 with both read enables", bus3.req_ready);
    end
    next_cycle();
    clear_reqs();
    repeat (2) next_cycle();
    settle();
    n_tests++;
    if (bus3.rsp_valid !== 4'b1010 || bus3.rsp_data[1*W +: W] !== 32'h11111111 || bus3.rsp_data[3*W +: W] !== 32'h33333333) begin
      n_fail++; $display("FAIL dual_response: got %b %h/%h want 1010 11111111/33333333",
                         bus3.rsp_valid, bus3.rsp_data[1*W +: W], bus3.rsp_data[3*W +: W]);
    end
  endtask

  task automatic test_single_requester();
    for (int it = 0; it < 3; it++) begin
      next_cycle();
      if (it == 0) begin
        clear_reqs();
        set_req(3, 1'b0, 10'h040, '0);
      end
      settle();
      n_tests++;
      if (bus3.req_ready !== 4'b1000 || {bus3.read_en_a, bus3.read_en_b} !== 2'b10 || bus3.address_b !== '0) begin
        n_fail++; $display("FAIL single_grant_%0d: got ready %b rd %b%b addr_b %h want 1000 10 000",
                           it, bus3.req_ready, bus3.read_en_a, bus3.read_en_b, bus3.address_b);
      end
      if (it > 0) begin
        n_tests++;
        if (ptr3 !== 2'd0) begin n_fail++; $display("FAIL single_rr_ptr_%0d: got %0d want 0", it, ptr3); end
      end
    end
    next_cycle();
    clear_reqs();
    settle();
    n_tests++;
    if (ptr3 !== 2'd0) begin n_fail++; $display("FAIL single_rr_ptr_end: got %0d want 0", ptr3); end
    repeat (4) next_cycle();
  endtask

  task automatic test_reset_inflight();
    next_cycle();
    clear_reqs();
    set_req(2, 1'b0, 10'h010, '0);
    settle();
    n_tests++;
    if (bus2.req_ready !== 4'b0100) begin n_fail++; $display("FAIL inflight_grant: got %b want 0100", bus2.req_ready); end
    next_cycle();
    reset = 1'b1;
    clear_reqs();
    set_req(0, 1'b0, 10'h010, '0);
    settle();
    n_tests++;
    if (bus2.req_ready !== 4'b0000 || {bus2.read_en_a, bus2.write_en_a, bus2.read_en_b, bus2.write_en_b} !== 4'b0000) begin
      n_fail++; $display("FAIL inflight_reset_gate: got ready %b want 0000 and no enables", bus2.req_ready);
    end
    next_cycle();
    reset = 1'b0;
    clear_reqs();
    set_req(1, 1'b0, 10'h030, '0);
    set_req(3, 1'b0, 10'h040, '0);
    settle();
    n_tests++;
    if (ptr2 !== 2'd0 || bus2.rsp_valid !== 4'b0000 || bus2.rsp_data !== '0) begin
      n_fail++; $display("FAIL inflight_after_reset: got ptr %0d valid %b data %h want 0 0000 0", ptr2, bus2.rsp_valid, bus2.rsp_data);
    end
    n_tests++;
    if (bus2.req_ready !== 4'b1010 || bus2.address_a !== 10'h030) begin
      n_fail++; $display("FAIL inflight_lowest_first: got ready %b addr_a %h want 1010 030", bus2.req_ready, bus2.address_a);
    end
    next_cycle();
    clear_reqs();
    settle();
    n_tests++;
    if (bus2.rsp_valid !== 4'b0000 || bus3.rsp_valid !== 4'b0000) begin
      n_fail++; $display("FAIL inflight_dropped: got %b/%b want 0000/0000", bus2.rsp_valid, bus3.rsp_valid);
    end
    next_cycle();
    settle();
    n_tests++;
    if (bus2.rsp_valid !== 4'b1010 || bus2.rsp_data[1*W +: W] !== 32'h11111111 || bus2.rsp_data[3*W +: W] !== 32'h33333333) begin
      n_fail++; $display("FAIL inflight_new_response: got %b %h/%h want 1010 11111111/33333333",
                         bus2.rsp_valid, bus2.rsp_data[1*W +: W], bus2.rsp_data[3*W +: W]);
    end
    next_cycle();
    settle();
    n_tests++;
    if (bus3.rsp_valid !== 4'b1010) begin n_fail++; $display("FAIL inflight_lat3_response: got %b want 1010", bus3.rsp_valid); end
  endtask

  initial begin
    reset = 1'b1;
    clear_reqs();
    repeat (3) @(posedge clk);
    test_reset();
    test_round_robin();
    test_read_latency();
    test_write_read_conflict();
    test_dual_response();
    test_single_requester();
    test_reset_inflight();
    repeat (2) next_cycle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_dp_arbiter.md
RAM_DP_ARBITER -- requirements
Module: ram_dp_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 32, data width.
REQ-003 SHALL have parameter WIDTHAD, default 10, address width.
REQ-004 SHALL have parameter LATENCY, default 1, read latency of attached dual-port RAM (1..4).
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port req_valid  input  NUM_REQ  per-requester request valid.
REQ-008 SHALL have port req_ready  output  NUM_REQ  per-requester grant; transfer when valid and ready both high.
REQ-009 SHALL have port req_write  input  NUM_REQ  1 = write, 0 = read.
REQ-010 SHALL have port req_addr  input  NUM_REQ*WIDTHAD  flattened addresses; requester i at [i*WIDTHAD +: WIDTHAD].
REQ-011 SHALL have port req_wdata  input  NUM_REQ*WIDTH  flattened write data.
REQ-012 SHALL have port rsp_valid  output  NUM_REQ  one-cycle read-data strobe per requester.
REQ-013 SHALL have port rsp_data  output  NUM_REQ*WIDTH  flattened read data, valid only with rsp_valid.
REQ-014 SHALL have ports clken, address_a/b, read_en_a/b, write_en_a/b, write_data_a/b  outputs, plus read_data_a/b  inputs, matching the dual-port RAM port widths (1, WIDTHAD, 1, 1, WIDTH, WIDTH).

Function
REQ-015 SHALL drive clken constantly 1; no stall path exists.
REQ-016 SHALL each cycle grant at most two requesters: port A to first valid requester in round-robin order from pointer rr_ptr, port B to next valid one after it.
REQ-017 SHALL advance rr_ptr to (last granted index + 1) mod NUM_REQ when any grant occurs; hold otherwise.
REQ-018 SHALL withhold the port B grant when A and B addresses match and either is a write; B candidate stays pending, no third requester is substituted.
REQ-019 SHALL assert req_ready combinationally in the grant cycle only; req_ready never high without req_valid.
REQ-020 SHALL drive granted address/write/data onto RAM port combinationally in the grant cycle; read_en = granted and not write, write_en = granted and write; idle port drives all enables 0, address 0.
REQ-021 SHALL track each granted read with a LATENCY-deep shift register per port holding {valid, requester index}.
REQ-022 SHALL assert rsp_valid[i] exactly LATENCY cycles after the grant cycle of a read from requester i, with rsp_data slice i = read_data of the granting port.
REQ-023 SHALL support responses on both ports in the same cycle to different requesters; a requester holds at most one grant per cycle, so no response collision occurs.
REQ-024 SHALL register rsp_data slices only on response; slice holds previous value otherwise.
REQ-025 SHALL generate no response for writes.

Reset
REQ-026 SHALL on reset set rr_ptr = 0, clear all tracking shift registers, rsp_valid = 0, rsp_data = 0.
REQ-027 SHALL drop in-flight reads on reset mid-operation; no rsp_valid in the LATENCY cycles after reset deasserts for pre-reset grants.
REQ-028 SHALL force req_ready = 0 and RAM enables = 0 while reset is high.

Verification
REQ-029 SHALL cover: NUM_REQ=4, all valid reads, rr_ptr=0 -> cycle 0 grants 0(A),1(B); cycle 1 grants 2(A),3(B); cycle 2 grants 0,1.
REQ-030 SHALL cover: LATENCY=3, requester 2 reads addr 0x10 holding 0xDEADBEEF -> rsp_valid[2] high exactly 3 cycles after grant, rsp_data slice 2 = 0xDEADBEEF.
REQ-031 SHALL cover: requester 0 writes addr 5, requester 1 reads addr 5 same cycle -> only 0 granted; 1 granted next cycle, reads new value.
REQ-032 SHALL cover: requesters 1 and 3 read different addresses same cycle -> both rsp_valid asserted same cycle, correct per-slice data.
REQ-033 SHALL cover: reset asserted one cycle after a read grant with LATENCY=2 -> no rsp_valid after reset, rr_ptr = 0, next grant goes to lowest valid index.
REQ-034 SHALL cover: single requester 3 valid continuously -> granted on port A every cycle, port B idle, rr_ptr = 0 after each grant.
